// File: rtl/polyphase_fir_decim.sv
// Polyphase decimating FIR: circular sample history, one multiply-accumulate per tap,
// floor-shifted and saturated output with valid/ready handshakes on both sides.
module polyphase_fir_decim #(
  parameter int unsigned DECIMATION_FACTOR = 9,
  parameter int unsigned TAP_LEN           = 63,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned COEF_WIDTH        = 16,
  parameter int unsigned OUT_SHIFT         = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic signed [DATA_WIDTH-1:0]  dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  input  logic                          coef_we,
  input  logic [$clog2(TAP_LEN)-1:0]    coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_wdata,
  output logic                          sat
);

  localparam int unsigned AW      = $clog2(TAP_LEN);
  localparam int unsigned FW      = $clog2(TAP_LEN + 1);
  localparam int unsigned PHW     = $clog2(DECIMATION_FACTOR);
  localparam int unsigned PW      = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned ACC_W   = PW + AW;
  localparam int unsigned LAST_PH = DECIMATION_FACTOR - 1;
  localparam int unsigned LAST_T  = TAP_LEN - 1;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  state_t                  state;
  logic [PHW-1:0]          phase;
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rptr;
  logic [AW-1:0]           tap;
  logic [FW-1:0]           fill;
  logic signed [DATA_WIDTH-1:0] hist [TAP_LEN];
  logic signed [COEF_WIDTH-1:0] coef [TAP_LEN];
  logic signed [PW-1:0]    prod;
  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc;
  logic                    done;

  logic                    xfer_c;
  logic                    trig_c;
  logic                    tap_live_c;
  logic signed [ACC_W-1:0] shifted_c;
  logic [ACC_W-DATA_WIDTH:0] hi_c;
  logic                    clip_c;
  logic signed [DATA_WIDTH-1:0] sat_val_c;

  // The trigger sample must never meet an unconsumed output, so it is held off at the last phase.
  assign din_ready  = (state == IDLE) && !(phase == PHW'(LAST_PH) && dout_valid);
  assign xfer_c     = din_valid && din_ready;
  assign trig_c     = xfer_c && (phase == PHW'(LAST_PH));
  assign tap_live_c = 32'(tap) < 32'(fill);

  // Floor shift, then clip when the bits above the output sign are not a pure sign extension.
  always_comb begin
    shifted_c = acc >>> OUT_SHIFT;
    hi_c      = shifted_c[ACC_W-1:DATA_WIDTH-1];
    clip_c    = !((&hi_c) || !(|hi_c));
    sat_val_c = shifted_c[DATA_WIDTH-1:0];
    if (clip_c) begin
      sat_val_c = shifted_c[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Storage and the product register; coefficient RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (xfer_c) hist[wptr] <= din;
    if (coef_we && state == IDLE && 32'(coef_addr) < TAP_LEN) coef[coef_addr] <= coef_wdata;
    prod <= tap_live_c ? PW'(hist[rptr]) * PW'(coef[tap]) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      tap        <= '0;
      fill       <= '0;
      prod_vld   <= 1'b0;
      acc        <= '0;
      done       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      prod_vld <= (state == MAC);
      done     <= (state == DRAIN);
      if (prod_vld) acc <= acc + ACC_W'(prod);

      case (state)
        IDLE: begin
          if (trig_c) begin
            state <= MAC;
            rptr  <= wptr;
            tap   <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          rptr <= (rptr == '0) ? AW'(LAST_T) : rptr - AW'(1);
          tap  <= tap + AW'(1);
          if (tap == AW'(LAST_T)) state <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase

      if (xfer_c) begin
        wptr  <= (wptr == AW'(LAST_T)) ? '0 : wptr + AW'(1);
        phase <= (phase == PHW'(LAST_PH)) ? '0 : phase + PHW'(1);
        if (fill != FW'(TAP_LEN)) fill <= fill + FW'(1);
      end

      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      if (done) begin
        dout       <= sat_val_c;
        dout_valid <= 1'b1;
        if (clip_c) sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_polyphase_fir_decim.sv
// Bench for polyphase_fir_decim: a sample-history convolution model predicts every output,
// plus directed scenarios with literal expectations.
module tb_polyphase_fir_decim;

  localparam int TAP = 63;
  localparam int DEC = 9;
  localparam int LAT = TAP + 2;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] din;
  logic din_valid;
  logic din_ready;
  logic signed [15:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic coef_we;
  logic [5:0] coef_addr;
  logic signed [15:0] coef_wdata;
  logic sat;

  always #5 clk = ~clk;

  polyphase_fir_decim dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .sat(sat)
  );

  typedef struct {
    logic signed [15:0] y;
    bit                 clip;
    int                 tc;
  } exp_t;

  int                 cyc = 0;
  logic signed [15:0] xs[$];
  logic signed [15:0] hm[TAP];
  int                 nacc;
  bit                 busy;
  int                 busy_end;
  exp_t               exp_q[$];
  logic signed [15:0] got_q[$];

  int ck_a = 0, fl_a = 0;
  int ck_b = 0, fl_b = 0;
  bit sat_exp;
  bit prev_vld;

  // Model: y[n] = sum h[t]*x[n-t] over the samples accepted since reset, floor >>15, clipped.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      xs.delete();
      exp_q.delete();
      nacc = 0;
      busy = 1'b0;
      busy_end = 0;
    end else begin
      if (dout_valid && dout_ready) begin
        got_q.push_back(dout);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (coef_we && int'(coef_addr) < TAP && !(busy && cyc <= busy_end))
        hm[coef_addr] = coef_wdata;
      if (din_valid && din_ready) begin
        xs.push_back(din);
        nacc = nacc + 1;
        if (nacc % DEC == 0) begin
          longint s;
          longint sh;
          exp_t e;
          s = 0;
          for (int t = 0; t < TAP; t++)
            if (t < xs.size()) s += longint'(hm[t]) * longint'(xs[xs.size()-1-t]);
          sh = s >>> 15;
          e.clip = (sh > 32767) || (sh < -32768);
          e.y = (sh > 32767) ? 16'sd32767 : (sh < -32768) ? -16'sd32768 : 16'(sh);
          e.tc = cyc;
          exp_q.push_back(e);
          busy = 1'b1;
          busy_end = cyc + TAP + 1;
        end
      end
    end
  end

  // Compare process: every visible output, its latency, and the sticky flag.
  always @(negedge clk) begin
    if (rst) begin
      sat_exp = 1'b0;
      prev_vld = 1'b0;
    end else begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          ck_a++; fl_a++;
          $display("FAIL unexpected_dout got=%0d want=no output", dout);
        end else begin
          if (!prev_vld) begin
            sat_exp = sat_exp | exp_q[0].clip;
            ck_a++;
            if (cyc - exp_q[0].tc != LAT) begin
              fl_a++;
              $display("FAIL latency got=%0d want=%0d", cyc - exp_q[0].tc, LAT);
            end
          end
          ck_a++;
          if (dout !== exp_q[0].y) begin
            fl_a++;
            $display("FAIL dout_model got=%0d want=%0d", dout, exp_q[0].y);
          end
        end
      end
      ck_a++;
      if (sat !== sat_exp) begin
        fl_a++;
        $display("FAIL sat_model got=%0b want=%0b", sat, sat_exp);
      end
      prev_vld = dout_valid;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    ck_b++;
    if (got != want) begin
      fl_b++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic load_coef(input int mode);
    for (int t = 0; t < TAP; t++) begin
      coef_we = 1'b1;
      coef_addr = 6'(t);
      coef_wdata = (mode == 0) ? 16'((t + 1) * 512) : (mode == 1) ? 16'sd1000 : 16'sd32767;
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic send(input int v);
    bit r;
    bit ok;
    ok = 1'b0;
    din = 16'(v);
    din_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      r = din_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    din_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic send_n(input int v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !dout_valid) break;
      tick();
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Impulse scaled so that (64 * (t+1)*512) >>> 15 == t+1, i.e. output equals h[t]/512.
  task automatic run_impulse(input string tag);
    int g0;
    g0 = got_q.size();
    send(64);
    send_n(0, 62 + DEC);
    drain();
    chk({tag, "_count"}, got_q.size() - g0, 8);
    for (int i = 0; i < 8; i++)
      chk({tag, "_dout"}, int'(got_q[g0 + i]), (i < 7) ? 9 * (i + 1) : 0);
  endtask

  initial begin
    int g0;
    logic signed [15:0] held;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_din_ready", int'(din_ready), 1);

    load_coef(0);
    run_impulse("impulse");

    // Reset in the middle of a MAC pass
    send(64);
    send_n(0, DEC - 1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmac_din_ready", int'(din_ready), 1);
    for (int i = 0; i < TAP + 5; i++) begin
      @(negedge clk);
      if (dout_valid) chk("rstmac_no_output", 1, 0);
    end
    tick();
    run_impulse("impulse_after_rst");

    // Coefficient write during MAC is ignored; the same write in IDLE lands
    do_reset();
    g0 = got_q.size();
    send(64);
    send_n(0, DEC - 1);
    repeat (3) tick();
    coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'sd0;
    tick();
    coef_we = 1'b0;
    drain();
    send_n(0, DEC - 1);
    send(64);
    drain();
    coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'sd0;
    tick();
    coef_we = 1'b0;
    send_n(0, DEC - 1);
    send(64);
    drain();
    chk("coefwr_count", got_q.size() - g0, 3);
    chk("coefwr_first", int'(got_q[g0]), 9);
    chk("coefwr_old_h0", int'(got_q[g0 + 1]), 19);
    chk("coefwr_new_h0", int'(got_q[g0 + 2]), 37);

    // Backpressure: output held, trigger sample stalled, nothing lost
    do_reset();
    load_coef(0);
    g0 = got_q.size();
    dout_ready = 1'b0;
    send(64);
    send_n(0, DEC - 1);
    for (int k = 0; k < 100 && !dout_valid; k++) tick();
    chk("bp_valid", int'(dout_valid), 1);
    held = dout;
    chk("bp_first", int'(held), 9);
    send_n(0, DEC - 1);
    din = '0;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_din_ready", int'(din_ready), 0);
      chk("bp_dout_stable", int'(dout), int'(held));
      chk("bp_valid_held", int'(dout_valid), 1);
      tick();
    end
    dout_ready = 1'b1;
    send(0);
    drain();
    chk("bp_count", got_q.size() - g0, 2);
    chk("bp_out0", int'(got_q[g0]), 9);
    chk("bp_out1", int'(got_q[g0 + 1]), 18);

    // DC gain
    do_reset();
    load_coef(1);
    g0 = got_q.size();
    send_n(1000, TAP + DEC);
    drain();
    chk("dc_count", got_q.size() - g0, 8);
    chk("dc_first", int'(got_q[g0]), 274);
    chk("dc_steady", int'(got_q[g0 + 7]), 1922);
    chk("dc_sat", int'(sat), 0);

    // Saturation both ways
    do_reset();
    load_coef(2);
    g0 = got_q.size();
    send_n(32767, DEC);
    drain();
    chk("satp_dout", int'(got_q[g0]), 32767);
    chk("satp_flag", int'(sat), 1);
    send_n(-32768, TAP);
    drain();
    chk("satn_count", got_q.size() - g0, 8);
    chk("satn_dout", int'(got_q[g0 + 7]), -32768);
    chk("satn_flag", int'(sat), 1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", ck_a + ck_b, fl_a + fl_b);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
